// File: rtl/pipe_fetch_unit_pkg.sv
// Shared widths, bubble word, pc_sel codes and control-transfer
// opcode classes (same encodings the CCG3 decoder uses).
package pipe_fetch_unit_pkg;

  localparam int PC_W    = 8;
  localparam int INSTR_W = 16;
  localparam int OP_W    = 8;
  localparam int OP_HI   = 15;
  localparam int OP_LO   = 8;

  localparam logic [PC_W-1:0]    RESET_PC_DEF  = 8'h00;
  localparam int                 BR_SHADOW_DEF = 3;
  localparam logic [INSTR_W-1:0] NOP_WORD      = 16'h0000;

  localparam logic [1:0] SEL_NONE  = 2'b00;
  localparam logic [1:0] SEL_OD    = 2'b01;
  localparam logic [1:0] SEL_STACK = 2'b10;
  localparam logic [1:0] SEL_ACC   = 2'b11;

  typedef enum logic {
    RUN,
    WAIT_BR
  } fetch_state_e;

  // control transfers: 03, 04..07, 08..0F, 28..2F, 30..3F, 48..4F
  localparam int N_CT = 6;
  localparam logic [N_CT-1:0][OP_W-1:0] CT_MASK =
    {8'hFF, 8'hFC, 8'hF8, 8'hF8, 8'hF0, 8'hF8};
  localparam logic [N_CT-1:0][OP_W-1:0] CT_VAL =
    {8'h03, 8'h04, 8'h08, 8'h28, 8'h30, 8'h48};

  // conditional families carry a flag selector in [2:0]
  localparam int N_CC = 3;
  localparam logic [N_CC-1:0][OP_W-1:0] CC_MASK =
    {8'hF8, 8'hF8, 8'hF8};
  localparam logic [N_CC-1:0][OP_W-1:0] CC_VAL =
    {8'h08, 8'h28, 8'h48};

  function automatic logic op_match(
    input logic [OP_W-1:0] op,
    input logic [OP_W-1:0] mask,
    input logic [OP_W-1:0] val
  );
    return (op & mask) == val;
  endfunction

  function automatic logic is_ctrl_op(input logic [OP_W-1:0] op);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < N_CT; i++)
      hit = hit | op_match(op, CT_MASK[i], CT_VAL[i]);
    return hit;
  endfunction

  function automatic logic is_cond_op(input logic [OP_W-1:0] op);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < N_CC; i++)
      hit = hit | op_match(op, CC_MASK[i], CC_VAL[i]);
    return hit;
  endfunction

endpackage

// File: rtl/pipe_fetch_unit_if.sv
// Fetch front-end bus: program memory, CCG1 outputs, CCG3 PC-load inputs.
// master = fetch unit, slave = pipeline/memory side. stall with PIPE_FETCH_STALL_EN.
interface pipe_fetch_unit_if;
  import pipe_fetch_unit_pkg::*;

  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic [3:0]         flags;
  logic               L_PC;
  logic [1:0]         pc_sel;
  logic [PC_W-1:0]    od_target;
  logic [PC_W-1:0]    acc_target;
  logic [PC_W-1:0]    stack_target;
  logic [INSTR_W-1:0] segment;
  logic               FL;
  logic [PC_W-1:0]    PC_in;
  logic               br_pending;
`ifdef PIPE_FETCH_STALL_EN
  logic               stall;

  modport master (
    output imem_addr, segment, FL, PC_in, br_pending,
    input  imem_rdata, flags, L_PC, pc_sel,
    input  od_target, acc_target, stack_target, stall
  );
  modport slave (
    input  imem_addr, segment, FL, PC_in, br_pending,
    output imem_rdata, flags, L_PC, pc_sel,
    output od_target, acc_target, stack_target, stall
  );
`else
  modport master (
    output imem_addr, segment, FL, PC_in, br_pending,
    input  imem_rdata, flags, L_PC, pc_sel,
    input  od_target, acc_target, stack_target
  );
  modport slave (
    input  imem_addr, segment, FL, PC_in, br_pending,
    output imem_rdata, flags, L_PC, pc_sel,
    output od_target, acc_target, stack_target
  );
`endif

endinterface

// File: rtl/pipe_fetch_predecode.sv
// Combinational pre-decode: control-transfer detect and FL evaluation.
// In: opcode, flags {S,Z,P,C}. Out: is_ctrl, fl.
module pipe_fetch_predecode
  import pipe_fetch_unit_pkg::*;
(
  input  logic [OP_W-1:0] opcode,
  input  logic [3:0]      flags,
  output logic            is_ctrl,
  output logic            fl
);

  // opcode[2] set means "branch if flag clear"
  always_comb begin
    is_ctrl = is_ctrl_op(opcode);
    fl      = 1'b0;
    if (is_cond_op(opcode))
      fl = flags[opcode[1:0]] ^ opcode[2];
  end

endmodule

// File: rtl/pipe_fetch_unit.sv
// Fetch front end: PC, program-memory read, branch bubbling, CCG3 PC loads.
// Ports: clk, rst (async high), bus (pipe_fetch_unit_if.master). Option: PIPE_FETCH_STALL_EN.
module pipe_fetch_unit
  import pipe_fetch_unit_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC  = RESET_PC_DEF,
  parameter int              BR_SHADOW = BR_SHADOW_DEF
) (
  input logic               clk,
  input logic               rst,
  pipe_fetch_unit_if.master bus
);

  localparam int CNT_W = $clog2(BR_SHADOW + 1);

  fetch_state_e       state;
  logic [PC_W-1:0]    pc;
  logic [PC_W-1:0]    pc_inc;
  logic [PC_W-1:0]    tgt;
  logic [CNT_W-1:0]   cnt;
  logic [INSTR_W-1:0] seg_q;
  logic [PC_W-1:0]    pcin_q;
  logic               fl_q;
  logic               pend_q;
  logic               is_ctrl;
  logic               fl_val;
  logic               load;
  logic               hold;

  assign bus.imem_addr  = pc;
  assign bus.segment    = seg_q;
  assign bus.FL         = fl_q;
  assign bus.PC_in      = pcin_q;
  assign bus.br_pending = pend_q;

  assign pc_inc = pc + PC_W'(1);

`ifdef PIPE_FETCH_STALL_EN
  assign hold = bus.stall;
`else
  assign hold = 1'b0;
`endif

  pipe_fetch_predecode u_predecode (
    .opcode  (bus.imem_rdata[OP_HI:OP_LO]),
    .flags   (bus.flags),
    .is_ctrl (is_ctrl),
    .fl      (fl_val)
  );

  always_comb begin
    load = bus.L_PC && (bus.pc_sel != SEL_NONE);
    tgt  = pc;
    unique case (bus.pc_sel)
      SEL_OD:    tgt = bus.od_target;
      SEL_ACC:   tgt = bus.acc_target;
      SEL_STACK: tgt = bus.stack_target;
      default:   tgt = pc;
    endcase
  end

  // A PC load beats stall and kills whatever was fetched this cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc     <= RESET_PC;
      state  <= RUN;
      cnt    <= '0;
      seg_q  <= NOP_WORD;
      fl_q   <= 1'b0;
      pcin_q <= '0;
      pend_q <= 1'b0;
    end else if (load) begin
      pc     <= tgt;
      state  <= RUN;
      cnt    <= '0;
      seg_q  <= NOP_WORD;
      fl_q   <= 1'b0;
      pcin_q <= '0;
      pend_q <= 1'b0;
    end else if (!hold) begin
      unique case (state)
        RUN: begin
          seg_q  <= bus.imem_rdata;
          fl_q   <= fl_val;
          pcin_q <= pc_inc;
          pc     <= pc_inc;
          if (is_ctrl) begin
            state  <= WAIT_BR;
            cnt    <= CNT_W'(BR_SHADOW);
            pend_q <= 1'b1;
          end
        end
        WAIT_BR: begin
          seg_q  <= NOP_WORD;
          fl_q   <= 1'b0;
          pcin_q <= '0;
          cnt    <= cnt - CNT_W'(1);
          // last shadow cycle: fall through
          if (cnt <= CNT_W'(1)) begin
            state  <= RUN;
            cnt    <= '0;
            pend_q <= 1'b0;
          end
        end
        default: begin
          state  <= RUN;
          pend_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_fetch_unit.sv
// Bench for pipe_fetch_unit: spec-level model checked every cycle
// plus directed literal checks of ordering, branches, wrap and reset.
module tb_pipe_fetch_unit;
  import pipe_fetch_unit_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic stall_tb;
  logic [15:0] rom [256];
  int n_checks = 0;
  int n_fail   = 0;

  pipe_fetch_unit_if bus ();

  assign bus.imem_rdata = rom[bus.imem_addr];
`ifdef PIPE_FETCH_STALL_EN
  assign bus.stall = stall_tb;
`endif

  pipe_fetch_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%h want=%h", name, $time, act, exp);
    end
  endtask

  // ---- reference model: works on opcode ranges and integer PC ----
  int          m_pc;
  int          m_nops;
  logic [15:0] m_seg;
  logic        m_fl;
  int          m_pcin;

  function automatic bit m_ctrl(input int op);
    return (op >= 'h03 && op <= 'h0F) || (op >= 'h28 && op <= 'h3F) ||
           (op >= 'h48 && op <= 'h4F);
  endfunction

  function automatic bit m_cond(input int op);
    return (op >= 'h08 && op <= 'h0F) || (op >= 'h28 && op <= 'h2F) ||
           (op >= 'h48 && op <= 'h4F);
  endfunction

  function automatic logic m_flag(input int op, input logic [3:0] f);
    logic s, z, p, c, v;
    {s, z, p, c} = f;
    case (op % 4)
      0: v = c;
      1: v = p;
      2: v = z;
      default: v = s;
    endcase
    if (!m_cond(op)) return 1'b0;
    return ((op / 4) % 2 == 1) ? !v : v;
  endfunction

  always @(posedge clk or posedge rst) begin
    int op;
    logic [15:0] w;
    if (rst) begin
      m_pc   <= 0;
      m_nops <= 0;
      m_seg  <= 16'h0000;
      m_fl   <= 1'b0;
      m_pcin <= 0;
    end else if (bus.L_PC && bus.pc_sel != 2'b00) begin
      case (bus.pc_sel)
        2'b01:   m_pc <= int'(bus.od_target);
        2'b11:   m_pc <= int'(bus.acc_target);
        default: m_pc <= int'(bus.stack_target);
      endcase
      m_nops <= 0;
      m_seg  <= 16'h0000;
      m_fl   <= 1'b0;
      m_pcin <= 0;
    end else if (stall_tb) begin
      m_pc <= m_pc;
    end else if (m_nops > 0) begin
      m_nops <= m_nops - 1;
      m_seg  <= 16'h0000;
      m_fl   <= 1'b0;
      m_pcin <= 0;
    end else begin
      w = rom[m_pc];
      op = int'(w[15:8]);
      m_seg  <= w;
      m_fl   <= m_flag(op, bus.flags);
      m_pcin <= (m_pc + 1) % 256;
      m_pc   <= (m_pc + 1) % 256;
      m_nops <= m_ctrl(op) ? 3 : 0;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("cmp_segment", 32'(bus.segment), 32'(m_seg));
      chk("cmp_fl", 32'(bus.FL), 32'(m_fl));
      chk("cmp_pc_in", 32'(bus.PC_in), 32'(m_pcin));
      chk("cmp_br_pending", 32'(bus.br_pending), 32'(m_nops > 0));
      chk("cmp_imem_addr", 32'(bus.imem_addr), 32'(m_pc));
    end
  end

  // ---- directed stimulus ----
  task automatic nxt();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    stall_tb = 1'b0;
    bus.flags = 4'b0000;
    bus.L_PC = 1'b0;
    bus.pc_sel = 2'b00;
    bus.od_target = 8'h00;
    bus.acc_target = 8'h00;
    bus.stack_target = 8'h00;
    for (int i = 0; i < 256; i++) rom[i] = 16'hA000 | 16'(i);
    rom[8'h00] = 16'h8001;
    rom[8'h01] = 16'h8002;
    rom[8'h02] = 16'h8003;
    rom[8'h03] = 16'h8004;
    rom[8'h04] = 16'h8105;
    rom[8'h05] = 16'h0540;
    rom[8'h40] = 16'h9140;
    rom[8'h10] = 16'h0A10;
    rom[8'h11] = 16'h0E11;

    nxt(); nxt();
    chk("rst_segment", 32'(bus.segment), 32'h0000);
    chk("rst_fl", 32'(bus.FL), 32'h0);
    chk("rst_pc_in", 32'(bus.PC_in), 32'h00);
    chk("rst_br_pending", 32'(bus.br_pending), 32'h0);
    chk("rst_imem_addr", 32'(bus.imem_addr), 32'h00);
    #1 rst = 1'b0;

    for (int k = 0; k < 4; k++) begin
      nxt();
      chk("ada_segment", 32'(bus.segment), 32'h8001 + 32'(k));
      chk("ada_pc_in", 32'(bus.PC_in), 32'(k + 1));
      chk("ada_no_bubble", 32'(bus.br_pending), 32'h0);
    end
    nxt();
    nxt();
    chk("jua_emit", 32'(bus.segment), 32'h0540);
    chk("jua_pending", 32'(bus.br_pending), 32'h1);
    nxt();
    chk("jua_nop1", 32'(bus.segment), 32'h0000);
    nxt();
    chk("jua_nop2", 32'(bus.segment), 32'h0000);
    #1;
    bus.L_PC = 1'b1;
    bus.pc_sel = 2'b11;
    bus.acc_target = 8'h40;
    nxt();
    chk("jua_nop3", 32'(bus.segment), 32'h0000);
    chk("jua_target_addr", 32'(bus.imem_addr), 32'h40);
    chk("jua_resolved", 32'(bus.br_pending), 32'h0);
    #1 bus.L_PC = 1'b0;
    nxt();
    chk("jua_target_word", 32'(bus.segment), 32'h9140);
    #1;
    bus.L_PC = 1'b1;
    bus.pc_sel = 2'b01;
    bus.od_target = 8'h10;
    nxt();
    chk("run_load_nop", 32'(bus.segment), 32'h0000);
    chk("run_load_addr", 32'(bus.imem_addr), 32'h10);
    #1;
    bus.L_PC = 1'b0;
    bus.flags = 4'b0100;
    nxt();
    chk("jcd_emit", 32'(bus.segment), 32'h0A10);
    chk("fl_z_set", 32'(bus.FL), 32'h1);
    nxt();
    chk("jcd_nop1", 32'(bus.segment), 32'h0000);
    #1;
    bus.L_PC = 1'b1;
    bus.pc_sel = 2'b00;
    nxt();
    chk("jcd_nop2", 32'(bus.segment), 32'h0000);
    #1 bus.L_PC = 1'b0;
    nxt();
    chk("jcd_nop3", 32'(bus.segment), 32'h0000);
    nxt();
    chk("jcd_fallthru", 32'(bus.segment), 32'h0E11);
    chk("fl_z_clear_test", 32'(bus.FL), 32'h0);
    chk("jcd_ft_pc_in", 32'(bus.PC_in), 32'h12);
    nxt(); nxt(); nxt(); nxt();
    chk("after_2nd_shadow", 32'(bus.segment), 32'hA012);
    #1;
    bus.L_PC = 1'b1;
    bus.pc_sel = 2'b10;
    bus.stack_target = 8'hFE;
    nxt();
    chk("stack_addr", 32'(bus.imem_addr), 32'hFE);
    #1 bus.L_PC = 1'b0;
    nxt();
    chk("word_fe", 32'(bus.segment), 32'hA0FE);
    nxt();
    chk("wrap_word", 32'(bus.segment), 32'hA0FF);
    chk("wrap_pc_in", 32'(bus.PC_in), 32'h00);
    chk("wrap_addr", 32'(bus.imem_addr), 32'h00);
    nxt();
    chk("wrap_next", 32'(bus.segment), 32'h8001);
    repeat (5) nxt();
    chk("jua2_emit", 32'(bus.segment), 32'h0540);
    nxt();
    #1 rst = 1'b1;
    #1;
    chk("rst_wait_addr", 32'(bus.imem_addr), 32'h00);
    chk("rst_wait_seg", 32'(bus.segment), 32'h0000);
    chk("rst_wait_pend", 32'(bus.br_pending), 32'h0);
    nxt();
    #1 rst = 1'b0;
    nxt();
    chk("post_rst_word", 32'(bus.segment), 32'h8001);
    chk("post_rst_pc_in", 32'(bus.PC_in), 32'h01);
`ifdef PIPE_FETCH_STALL_EN
    #1 stall_tb = 1'b1;
    nxt();
    chk("stall1_seg", 32'(bus.segment), 32'h8001);
    chk("stall1_addr", 32'(bus.imem_addr), 32'h01);
    nxt();
    chk("stall2_seg", 32'(bus.segment), 32'h8001);
    chk("stall2_addr", 32'(bus.imem_addr), 32'h01);
    #1;
    bus.L_PC = 1'b1;
    bus.pc_sel = 2'b01;
    bus.od_target = 8'h30;
    nxt();
    chk("stall_load_addr", 32'(bus.imem_addr), 32'h30);
    chk("stall_load_nop", 32'(bus.segment), 32'h0000);
    #1;
    bus.L_PC = 1'b0;
    stall_tb = 1'b0;
    nxt();
    chk("stall_load_word", 32'(bus.segment), 32'hA030);
`endif
    nxt(); nxt();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
